mem_reg_src: RTL

MEM_REG_SRC -- requirements
Module: mem_reg_src

---
 rtl/mem_reg_src.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_reg_src.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_reg_src
//   Source side of a four-phase return-to-zero dual-rail link. A binary word is
//   accepted on a valid/ready handshake, registered and driven as a dual-rail
//   codeword until the downstream sink acknowledges. The link then returns to
//   all-spacer and waits for the acknowledge to drop before it accepts the
//   next word.
//
//   Dual-rail encoding per bit: 2'b10 = logic 1, 2'b01 = logic 0,
//   2'b00 = spacer. 2'b11 is never driven.
//
// Parameters
//   WIDTH       : number of dual-rail bits on the link
//   SYNC_STAGES : flop count of the ack_i synchronizer (legal 2..4)
//   TIMEOUT     : watchdog limit in clk cycles (timeout build only)
//   RAIL_NUM    : rails per bit (fixed at 2)
//
// Ports
//   clk      : single clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   in_data  : binary word to send
//   in_valid : in_data is valid
//   in_ready : a word is accepted this cycle when in_valid is also high
//   out      : dual-rail link to the downstream register sink (flop outputs)
//   ack_i    : asynchronous completion from the downstream sink
//   busy     : a handshake is in flight (state not IDLE)
//   err      : sticky watchdog flag (only with MEM_REG_SRC_TIMEOUT_EN)
//
// Build option
//   MEM_REG_SRC_TIMEOUT_EN : when defined, adds the err output and a watchdog
//   counter that flags a handshake stuck in DATA or SPACER for TIMEOUT cycles.
// -----------------------------------------------------------------------------
module mem_reg_src #(
  parameter  int WIDTH       = 1,
  parameter  int SYNC_STAGES = 2,
  parameter  int TIMEOUT     = 1024,
  localparam int RAIL_NUM    = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [WIDTH-1:0]                   in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]     out,
  input  logic                               ack_i,
  output logic                               busy
`ifdef MEM_REG_SRC_TIMEOUT_EN
  ,
  output logic                               err
`endif
);

  // Parameter legality is checked at elaboration so a bad build never
  // reaches synthesis with a one-flop synchronizer or a zero timeout.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_reg_src: SYNC_STAGES must be 2..4 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    SPACER = 2'd2
  } state_e;

  typedef logic [WIDTH-1:0][RAIL_NUM-1:0] link_t;

  // Binary to dual-rail: rail 1 carries the bit, rail 0 its complement, so
  // a valid data codeword can never be 2'b11 or 2'b00.
  function automatic link_t encode(input logic [WIDTH-1:0] word);
    link_t code;
    for (int i = 0; i < WIDTH; i++) begin
      code[i] = {word[i], ~word[i]};
    end
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // ack_i synchronizer
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  // NOTE: synchronizer flops are reset so a stale ack seen before reset
  // cannot leak into the FSM; the first cycles after release always read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every flop in the chain sample the
      // previous-cycle value of its neighbour, giving a real shift register.
      sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Post-reset warm-up: in_ready is held low for SYNC_STAGES cycles after
  // reset release so the synchronizer has flushed in a fresh view of ack_i
  // before the first word can be taken.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] warm_q;
  logic                   warm_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q <= '0;
    end else begin
      warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign warm_done = warm_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Handshake FSM and link register
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  link_t  out_q,   out_d;

  // A word is only taken in IDLE once the previous ack has fully returned to
  // zero; a stale ack in IDLE keeps in_ready low until it clears.
  assign in_ready = (state_q == IDLE) && warm_done && !ack_s;
  assign busy     = (state_q != IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    state_d = state_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          out_d   = encode(in_data);
          state_d = DATA;
        end
      end
      DATA: begin
        // in_data is not looked at here: the registered codeword is held.
        if (ack_s) begin
          out_d   = '0;
          state_d = SPACER;
        end
      end
      SPACER: begin
        if (!ack_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        out_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // The link is driven straight from flops so the sink never sees glitches.
  assign out = out_q;

`ifdef MEM_REG_SRC_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Watchdog: counts cycles spent in one busy state, restarts on every state
  // change and saturates at TIMEOUT. err is raised on the edge the count
  // reaches TIMEOUT and stays set until reset. It never feeds back into the
  // FSM or the link.
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != IDLE && cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    err_d = err_q | (cnt_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule
